// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and RAM handshake signals for mem_port_arbiter.
// master = requesters plus RAM model side, slave = the arbiter itself.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;

  logic        ls_req;
  logic        ls_we;
  logic [2:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_ack;
  logic [31:0] ls_rdata;

  logic        ram_start;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [2:0]  ram_size;
  logic [31:0] ram_rdata;
  logic        ram_busy;
  logic        ram_done;

  logic        busy;
  logic        err;

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata,
           ram_rdata, ram_busy, ram_done,
    input  if_ack, if_rdata, ls_ack, ls_rdata,
           ram_start, ram_addr, ram_wdata, ram_we, ram_size, busy, err
  );

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata,
           ram_rdata, ram_busy, ram_done,
    output if_ack, if_rdata, ls_ack, ls_rdata,
           ram_start, ram_addr, ram_wdata, ram_we, ram_size, busy, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between fetch and load/store, one access in flight.
// Optional WAIT timeout with err flag is built only when ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  // MEM_WORD encoding from opcode.h
  localparam logic [2:0] MemWord = 3'd2;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic        gnt_ls_q;  // last/current winner: 1 = LSU
  logic [31:0] addr_q, wdata_q, if_rdata_q, ls_rdata_q;
  logic        we_q;
  logic [2:0]  size_q;

  logic win_any, win_ls, done_ok, timeout;

  assign win_any = bus.if_req | bus.ls_req;
  assign win_ls  = bus.ls_req & (~bus.if_req | ~gnt_ls_q);
  assign done_ok = bus.ram_done & ~bus.ram_busy;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;
  logic            err_q;

  assign timeout = (state_q == StWait) & ~done_ok & (cnt_q == CntLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == StIssue) begin
        cnt_q <= '0;
      end else if (state_q == StWait) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == StIdle) begin
        err_q <= 1'b0;
      end else if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (win_any) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (done_ok || timeout) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.ram_start = (state_q == StIssue);
    bus.busy      = (state_q != StIdle);
    bus.if_ack    = (state_q == StResp) & ~gnt_ls_q;
    bus.ls_ack    = (state_q == StResp) & gnt_ls_q;
`ifdef ARB_TIMEOUT_EN
    bus.err       = (state_q == StResp) & err_q;
`else
    bus.err       = 1'b0;
`endif
  end

  // Command is latched only on a win, so it stays stable from ISSUE through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_ls_q   <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      if (state_q == StIdle && win_any) begin
        gnt_ls_q <= win_ls;
        addr_q   <= win_ls ? bus.ls_addr : bus.if_addr;
        wdata_q  <= win_ls ? bus.ls_wdata : 32'h0;
        we_q     <= win_ls & bus.ls_we;
        size_q   <= win_ls ? bus.ls_size : MemWord;
      end
      if (state_q == StWait) begin
        if (done_ok) begin
          if (!gnt_ls_q) begin
            if_rdata_q <= bus.ram_rdata;
          end else if (!we_q) begin
            ls_rdata_q <= bus.ram_rdata;
          end
        end else if (timeout) begin
          if (!gnt_ls_q) begin
            if_rdata_q <= '0;
          end else begin
            ls_rdata_q <= '0;
          end
        end
      end
    end
  end

  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.ram_we    = we_q;
  assign bus.ram_size  = size_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural RAM.
// Covers fetch, store/load, round-robin ties, stale done, slow RAM, reset mid-op and timeout.
module tb_mem_port_arbiter;

  localparam logic [2:0] MemWord = 3'd2;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: sees start mid-cycle, busy for ram_lat-1 cycles, then a one-cycle done.
  logic [31:0] mem [0:255];
  int          ram_lat;
  bit          ram_never;
  int          cnt;
  logic [7:0]  idx;
  logic        m_done;
  logic        inj_done;

  assign bus.ram_done = m_done | inj_done;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'h0050_0093;
    mem[8'h41] = 32'hCAFE_F00D;
    cnt          = 0;
    idx          = '0;
    m_done       = 1'b0;
    bus.ram_busy = 1'b0;
    bus.ram_rdata = 32'h0;
  end

  always @(negedge clk) begin
    if (bus.ram_start) begin
      cnt    <= ram_lat;
      idx    <= bus.ram_addr[9:2];
      m_done <= 1'b0;
      bus.ram_busy <= 1'b0;
      if (bus.ram_we) mem[bus.ram_addr[9:2]] <= bus.ram_wdata;
    end else if (cnt > 1 || (cnt == 1 && ram_never)) begin
      bus.ram_busy <= 1'b1;
      m_done       <= 1'b0;
      if (!ram_never) cnt <= cnt - 1;
    end else if (cnt == 1) begin
      bus.ram_busy  <= 1'b0;
      m_done        <= 1'b1;
      bus.ram_rdata <= mem[idx];
      cnt           <= 0;
    end else begin
      bus.ram_busy <= 1'b0;
      m_done       <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Steps until either ack is high; n = cycles elapsed, bounded at 60.
  task automatic wait_ack(output int n);
    n = 0;
    while (!(bus.if_ack || bus.ls_ack) && n < 60) begin
      tick();
      n++;
    end
  endtask

  int n;
  int acks;

  initial begin
    rst = 1'b1;
    bus.if_req = 0; bus.if_addr = 0;
    bus.ls_req = 0; bus.ls_we = 0; bus.ls_size = 0; bus.ls_addr = 0; bus.ls_wdata = 0;
    inj_done = 0; ram_lat = 1; ram_never = 0;
    n_pass = 0; n_total = 0;
    tick(); tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_start", bus.ram_start, 0);
    chk("rst_acks", {bus.if_ack, bus.ls_ack}, 0);
    chk("rst_rdata", bus.if_rdata | bus.ls_rdata, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_cmd", bus.ram_addr, 0);
    rst = 1'b0;
    tick();

    // Single fetch
    bus.if_req = 1; bus.if_addr = 32'h100;
    tick();
    chk("f_start", bus.ram_start, 1);
    chk("f_addr", bus.ram_addr, 32'h100);
    chk("f_we", bus.ram_we, 0);
    chk("f_size", bus.ram_size, MemWord);
    chk("f_wdata", bus.ram_wdata, 0);
    chk("f_busy", bus.busy, 1);
    tick();
    chk("f_start_drop", bus.ram_start, 0);
    tick();
    chk("f_ack", bus.if_ack, 1);
    chk("f_rdata", bus.if_rdata, 32'h0050_0093);
    chk("f_ls_ack", bus.ls_ack, 0);
    chk("f_err", bus.err, 0);
    bus.if_req = 0;
    tick();
    chk("f_ack_pulse", bus.if_ack, 0);
    chk("f_idle", bus.busy, 0);

    // Store then load
    bus.ls_req = 1; bus.ls_we = 1; bus.ls_size = MemWord;
    bus.ls_addr = 32'h200; bus.ls_wdata = 32'hDEAD_BEEF;
    tick();
    chk("st_we", bus.ram_we, 1);
    chk("st_wdata", bus.ram_wdata, 32'hDEAD_BEEF);
    chk("st_addr", bus.ram_addr, 32'h200);
    wait_ack(n);
    chk("st_lat", n, 2);
    chk("st_ack", bus.ls_ack, 1);
    chk("st_if_ack", bus.if_ack, 0);
    chk("st_rdata_hold", bus.ls_rdata, 0);
    bus.ls_req = 0;
    tick();
    bus.ls_req = 1; bus.ls_we = 0; bus.ls_wdata = 32'h1234_5678;
    wait_ack(n);
    chk("ld_lat", n, 3);
    chk("ld_ack", bus.ls_ack, 1);
    chk("ld_rdata", bus.ls_rdata, 32'hDEAD_BEEF);
    chk("ld_we", bus.ram_we, 0);
    chk("if_rdata_stable", bus.if_rdata, 32'h0050_0093);
    bus.ls_req = 0;
    tick();

    // Tie after reset, then alternation with both held
    rst = 1; tick(); rst = 0;
    bus.if_req = 1; bus.if_addr = 32'h104;
    bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      wait_ack(n);
      chk("rr_lat", n, 3);
      chk("rr_if_ack", bus.if_ack, (i % 2 == 0) ? 1 : 0);
      chk("rr_ls_ack", bus.ls_ack, (i % 2 == 1) ? 1 : 0);
      tick();
    end
    chk("rr_if_rdata", bus.if_rdata, 32'hCAFE_F00D);
    chk("rr_ls_rdata", bus.ls_rdata, 32'hDEAD_BEEF);
    bus.if_req = 0; bus.ls_req = 0;
    tick(); tick();

    // Stale done in IDLE, then slow RAM
    inj_done = 1;
    tick();
    inj_done = 0;
    chk("stale_busy", bus.busy, 0);
    chk("stale_ack", {bus.if_ack, bus.ls_ack}, 0);
    tick();
    chk("stale_ack2", {bus.if_ack, bus.ls_ack}, 0);
    ram_lat = 11;
    bus.if_req = 1; bus.if_addr = 32'h100;
    wait_ack(n);
    chk("slow_lat", n, 13);
    chk("slow_ack", bus.if_ack, 1);
    chk("slow_rdata", bus.if_rdata, 32'h0050_0093);
    bus.if_req = 0;
    tick();

    // Reset in WAIT, stale done from the aborted access must be ignored
    bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 32'h104;
    tick(); tick(); tick();
    chk("mid_in_wait", bus.busy, 1);
    rst = 1;
    #1;
    chk("mid_busy", bus.busy, 0);
    chk("mid_start", bus.ram_start, 0);
    chk("mid_ack", {bus.if_ack, bus.ls_ack}, 0);
    bus.ls_req = 0;
    tick();
    rst = 0;
    acks = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (bus.if_ack || bus.ls_ack || bus.busy) acks++;
    end
    chk("mid_no_ack", acks, 0);
    chk("mid_ls_rdata", bus.ls_rdata, 0);
    ram_lat = 1;
    bus.if_req = 1; bus.ls_req = 1;
    wait_ack(n);
    chk("mid_tie_if", bus.if_ack, 1);
    chk("mid_tie_ls", bus.ls_ack, 0);
    bus.if_req = 0; bus.ls_req = 0;
    tick(); tick();

    // RAM never completes
    ram_never = 1;
    bus.if_req = 1; bus.if_addr = 32'h104;
`ifdef ARB_TIMEOUT_EN
    wait_ack(n);
    chk("to_lat", n, 10);
    chk("to_ack", bus.if_ack, 1);
    chk("to_err", bus.err, 1);
    chk("to_rdata", bus.if_rdata, 0);
    bus.if_req = 0;
    tick();
    chk("to_idle", bus.busy, 0);
    chk("to_err_pulse", bus.err, 0);
`else
    for (int i = 0; i < 30; i++) tick();
    chk("hang_busy", bus.busy, 1);
    chk("hang_err", bus.err, 0);
    chk("hang_ack", bus.if_ack, 0);
    bus.if_req = 0;
    rst = 1; tick(); rst = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
